// File: rtl/i2c_scl_bit_engine_if.sv
// Command/status bundle between the byte-level I2C master FSM and the
// SCL bit engine. The master modport is the upstream FSM side.
interface i2c_scl_bit_engine_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] t_low;
  logic [CNT_W-1:0] t_high;
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_bit;
  logic             cmd_ready;
  logic             done;
  logic             err;
  logic             rx_bit;

  modport master (
    output t_low, t_high, cmd_valid, cmd, cmd_bit,
    input  cmd_ready, done, err, rx_bit
  );

  modport slave (
    input  t_low, t_high, cmd_valid, cmd, cmd_bit,
    output cmd_ready, done, err, rx_bit
  );
endinterface

// File: rtl/i2c_scl_bit_engine.sv
// I2C master SCL/SDA bit engine: START, BIT, STOP, RSTART with clock stretch.
// Define I2C_SCL_STRETCH_TIMEOUT_EN to abort when a slave holds SCL low too long.
module i2c_scl_bit_engine #(
  parameter int CNT_W   = 16,
  parameter int SDA_DLY = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_scl_bit_engine_if.slave   cif,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic                  sda_tick,
  output logic                  bus_busy
);

  localparam logic [3:0] FREE      = 4'd0;
  localparam logic [3:0] ST_SU     = 4'd1;
  localparam logic [3:0] ST_HD     = 4'd2;
  localparam logic [3:0] HELD      = 4'd3;
  localparam logic [3:0] LOW       = 4'd4;
  localparam logic [3:0] HIGH_WAIT = 4'd5;
  localparam logic [3:0] HIGH      = 4'd6;
  localparam logic [3:0] P_SU      = 4'd7;
  localparam logic [3:0] P_BUF     = 4'd8;
  localparam logic [3:0] RS_SU     = 4'd9;
  localparam logic [3:0] RS_HD     = 4'd10;

  localparam logic [1:0] C_START  = 2'b00;
  localparam logic [1:0] C_BIT    = 2'b01;
  localparam logic [1:0] C_STOP   = 2'b10;
  localparam logic [1:0] C_RSTART = 2'b11;

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic [CNT_W-1:0] th_q;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] tl_c;
  logic [CNT_W-1:0] th_c;
  logic [1:0]       cmd_q;
  logic             bit_q;
  logic             done_q;
  logic             err_q;
  logic             rx_q;
  logic             tick_q;
  logic             idle;
  logic             acc;
  logic             last;
  logic [TO_W-1:0]  to_cnt;
  logic             to_hit;

  function automatic logic [CNT_W-1:0] clamp2(
    input logic [CNT_W-1:0] v
  );
    return (v < CNT_W'(2)) ? CNT_W'(2) : v;
  endfunction

  // SDA level driven during the SCL-low phase of each command.
  function automatic logic low_sda(
    input logic [1:0] c,
    input logic       b
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (c == C_BIT):  r = ~b;
      (c == C_STOP): r = 1'b1;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  assign idle          = (state == FREE) || (state == HELD);
  assign cif.cmd_ready = idle && !done_q;
  assign acc           = cif.cmd_valid && cif.cmd_ready;
  assign tl_c          = clamp2(cif.t_low);
  assign th_c          = clamp2(cif.t_high);
  assign elapsed       = lim - cnt;
  assign last          = (cnt == '0);
  assign cif.done      = done_q;
  assign cif.err       = err_q;
  assign cif.rx_bit    = rx_q;
  assign sda_tick      = tick_q;

  // Stretch watchdog; folded away when the timeout feature is off.
  assign to_hit = TO_EN && !scl_i &&
                  (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == HIGH_WAIT && !scl_i) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FREE;
      cnt      <= '0;
      lim      <= '0;
      th_q     <= '0;
      cmd_q    <= C_START;
      bit_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rx_q     <= 1'b0;
      tick_q   <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      bus_busy <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      tick_q <= 1'b0;
      if (!last) cnt <= cnt - 1'b1;
      case (state)
        FREE: if (acc) begin
          if (cif.cmd == C_START) begin
            cmd_q    <= cif.cmd;
            bit_q    <= cif.cmd_bit;
            th_q     <= th_c;
            cnt      <= th_c - 1'b1;
            lim      <= th_c - 1'b1;
            bus_busy <= 1'b1;
            state    <= ST_SU;
          end else begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end
        end
        ST_SU: if (last) begin
          sda_oe <= 1'b1;
          cnt    <= th_q - 1'b1;
          lim    <= th_q - 1'b1;
          state  <= ST_HD;
        end
        ST_HD: if (last) begin
          scl_oe <= 1'b1;
          done_q <= 1'b1;
          state  <= HELD;
        end
        HELD: if (acc) begin
          if (cif.cmd == C_START) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            cmd_q <= cif.cmd;
            bit_q <= cif.cmd_bit;
            th_q  <= th_c;
            cnt   <= tl_c - 1'b1;
            lim   <= tl_c - 1'b1;
            state <= LOW;
            if (SDA_DLY == 0) begin
              tick_q <= 1'b1;
              sda_oe <= low_sda(cif.cmd, cif.cmd_bit);
            end
          end
        end
        LOW: begin
          // Registered one cycle early so tick and SDA appear at SDA_DLY.
          if (SDA_DLY != 0 &&
              elapsed == CNT_W'(SDA_DLY - 1)) begin
            tick_q <= 1'b1;
            sda_oe <= low_sda(cmd_q, bit_q);
          end
          if (last) begin
            scl_oe <= 1'b0;
            state  <= HIGH_WAIT;
          end
        end
        HIGH_WAIT: begin
          if (scl_i) begin
            cnt   <= th_q - 1'b1;
            lim   <= th_q - 1'b1;
            state <= HIGH;
          end else if (to_hit) begin
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            bus_busy <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= 1'b1;
            state    <= FREE;
          end
        end
        HIGH: begin
          if (cmd_q == C_BIT && elapsed == (th_q >> 1))
            rx_q <= sda_i;
          if (last) begin
            unique case (1'b1)
              (cmd_q == C_STOP): begin
                sda_oe <= 1'b0;
                state  <= P_SU;
              end
              (cmd_q == C_RSTART): state <= RS_SU;
              default: begin
                scl_oe <= 1'b1;
                done_q <= 1'b1;
                state  <= HELD;
              end
            endcase
          end
        end
        P_SU: begin
          cnt   <= th_q - 1'b1;
          lim   <= th_q - 1'b1;
          state <= P_BUF;
        end
        P_BUF: if (last) begin
          bus_busy <= 1'b0;
          done_q   <= 1'b1;
          state    <= FREE;
        end
        RS_SU: begin
          sda_oe <= 1'b1;
          cnt    <= th_q - 1'b1;
          lim    <= th_q - 1'b1;
          state  <= RS_HD;
        end
        RS_HD: if (last) begin
          scl_oe <= 1'b1;
          done_q <= 1'b1;
          state  <= HELD;
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_bit_engine.sv
// Directed bench for i2c_scl_bit_engine; cycle numbers count negedges
// after the accepting posedge (c1 = first cycle after accept).
module tb_i2c_scl_bit_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_i, sda_i, scl_oe, sda_oe, sda_tick, bus_busy;
  logic hold = 1'b0;
  logic sda_drv = 1'b1;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int n, d0;

  localparam logic [1:0] START  = 2'b00;
  localparam logic [1:0] BIT    = 2'b01;
  localparam logic [1:0] STOP   = 2'b10;
  localparam logic [1:0] RSTART = 2'b11;

  i2c_scl_bit_engine_if #(.CNT_W(16)) tif();

  i2c_scl_bit_engine #(
    .CNT_W(16), .SDA_DLY(2), .TIMEOUT(4096)
  ) dut (
    .clk(clk), .reset(reset), .cif(tif),
    .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .sda_tick(sda_tick), .bus_busy(bus_busy)
  );

  always #5 clk = ~clk;

  // Open-drain pads: slave may hold SCL low or drive SDA low.
  assign scl_i = ~scl_oe & ~hold;
  assign sda_i = ~sda_oe & sda_drv;

  always @(posedge clk) if (tif.done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] c, input logic b,
                       input int tl, input int th);
    tif.cmd_valid = 1'b1;
    tif.cmd       = c;
    tif.cmd_bit   = b;
    tif.t_low     = 16'(tl);
    tif.t_high    = 16'(th);
    @(negedge clk);
    tif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget,
                           output int cyc);
    cyc = start;
    while (tif.done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    tif.cmd_valid = 1'b0;
    tif.cmd       = START;
    tif.cmd_bit   = 1'b0;
    tif.t_low     = 16'd5;
    tif.t_high    = 16'd4;
    @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_ready", tif.cmd_ready, 1);
    chk("rst_done", tif.done, 0);
    chk("rst_err", tif.err, 0);
    chk("rst_rx", tif.rx_bit, 0);
    chk("rst_tick", sda_tick, 0);
    chk("rst_busy", bus_busy, 0);
    reset = 1'b0;
    run(2);

    // START t_low=5 t_high=4: ST_SU c1-4, ST_HD c5-8, HELD c9
    issue(START, 1'b0, 5, 4);
    chk("st_ready_drop", tif.cmd_ready, 0);
    chk("st_busy", bus_busy, 1);
    run(3);
    chk("st_su_sda", sda_oe, 0);
    run(1);
    chk("st_hd_sda", sda_oe, 1);
    chk("st_hd_scl", scl_oe, 0);
    run(3);
    chk("st_hd_scl_end", scl_oe, 0);
    run(1);
    chk("st_held_scl", scl_oe, 1);
    chk("st_done", tif.done, 1);
    chk("st_err", tif.err, 0);
    chk("st_ready_in_done", tif.cmd_ready, 0);
    run(1);
    chk("st_done_pulse", tif.done, 0);
    chk("st_ready_back", tif.cmd_ready, 1);

    // BIT 0, t_low=6: LOW c1-6, HIGH_WAIT c7, HIGH c8-11, done c12
    issue(BIT, 1'b0, 6, 4);
    chk("b0_scl_low", scl_oe, 1);
    chk("b0_tick_early", sda_tick, 0);
    run(2);
    chk("b0_tick", sda_tick, 1);
    chk("b0_sda", sda_oe, 1);
    run(1);
    chk("b0_tick_pulse", sda_tick, 0);
    run(2);
    chk("b0_scl_low_end", scl_oe, 1);
    run(1);
    chk("b0_scl_rel", scl_oe, 0);
    run(4);
    chk("b0_scl_high_end", scl_oe, 0);
    chk("b0_no_done", tif.done, 0);
    run(1);
    chk("b0_done", tif.done, 1);
    chk("b0_scl_held", scl_oe, 1);
    chk("b0_sda_kept", sda_oe, 1);
    chk("b0_rx", tif.rx_bit, 0);
    run(1);

    // Read bits: SDA released, slave drives 0 then 1
    sda_drv = 1'b0;
    issue(BIT, 1'b1, 6, 4);
    wait_done(1, 60, n);
    chk("rd0_len", n, 12);
    chk("rd0_rx", tif.rx_bit, 0);
    chk("rd0_sda_rel", sda_oe, 0);
    run(1);
    sda_drv = 1'b1;
    issue(BIT, 1'b1, 6, 4);
    wait_done(1, 60, n);
    chk("rd1_len", n, 12);
    chk("rd1_rx", tif.rx_bit, 1);
    run(1);

    // Stretch: slave holds SCL for 20 HIGH_WAIT cycles (c7-c26)
    d0   = done_cnt;
    hold = 1'b1;
    issue(BIT, 1'b1, 6, 4);
    run(5);
    chk("str_scl_low", scl_oe, 1);
    run(1);
    chk("str_scl_rel", scl_oe, 0);
    chk("str_pad_low", scl_i, 0);
    run(19);
    chk("str_no_done", tif.done, 0);
    hold = 1'b0;
    wait_done(26, 80, n);
    chk("str_len", n, 6 + 20 + 4 + 1);
    run(2);
    chk("str_done_once", done_cnt - d0, 1);

    // STOP: LOW c1-6, HW c7, HIGH c8-11, P_SU c12, P_BUF c13-16, FREE c17
    issue(STOP, 1'b0, 6, 4);
    run(2);
    chk("sp_sda_low", sda_oe, 1);
    chk("sp_scl_low", scl_oe, 1);
    run(8);
    chk("sp_high_sda", sda_oe, 1);
    chk("sp_high_scl", scl_oe, 0);
    run(1);
    chk("sp_sda_rel", sda_oe, 0);
    chk("sp_scl_rel", scl_oe, 0);
    run(4);
    chk("sp_buf_busy", bus_busy, 1);
    chk("sp_buf_nodone", tif.done, 0);
    run(1);
    chk("sp_done", tif.done, 1);
    chk("sp_busy_clr", bus_busy, 0);
    chk("sp_err", tif.err, 0);
    run(1);
    chk("sp_ready", tif.cmd_ready, 1);

    // Illegal STOP in FREE
    issue(STOP, 1'b0, 6, 4);
    chk("il_stop_done", tif.done, 1);
    chk("il_stop_err", tif.err, 1);
    chk("il_stop_scl", scl_oe, 0);
    chk("il_stop_sda", sda_oe, 0);
    chk("il_stop_busy", bus_busy, 0);
    chk("il_stop_ready", tif.cmd_ready, 0);
    run(1);
    chk("il_stop_err_pulse", tif.err, 0);
    chk("il_stop_ready_back", tif.cmd_ready, 1);

    // START accepted again after STOP
    issue(START, 1'b0, 5, 4);
    wait_done(1, 40, n);
    chk("st2_len", n, 9);
    chk("st2_busy", bus_busy, 1);
    chk("st2_scl", scl_oe, 1);
    chk("st2_sda", sda_oe, 1);
    run(1);

    // Illegal START in HELD
    issue(START, 1'b0, 5, 4);
    chk("il_st_done", tif.done, 1);
    chk("il_st_err", tif.err, 1);
    chk("il_st_scl", scl_oe, 1);
    chk("il_st_sda", sda_oe, 1);
    run(1);

    // RSTART t_low=5 t_high=3: HW c6, HIGH c7-9, RS_SU c10, RS_HD c11-13
    issue(RSTART, 1'b0, 5, 3);
    run(2);
    chk("rs_sda_rel", sda_oe, 0);
    run(7);
    chk("rs_su_sda", sda_oe, 0);
    chk("rs_su_scl", scl_oe, 0);
    run(1);
    chk("rs_hd_sda", sda_oe, 1);
    chk("rs_hd_scl", scl_oe, 0);
    run(3);
    chk("rs_done", tif.done, 1);
    chk("rs_scl", scl_oe, 1);
    chk("rs_busy", bus_busy, 1);
    run(1);

    // t_low=0, t_high=1 clamp to 2; later changes ignored
    issue(BIT, 1'b0, 0, 1);
    tif.t_low  = 16'd50;
    tif.t_high = 16'd50;
    wait_done(1, 80, n);
    chk("clamp_len", n, 2 + 1 + 2 + 1);
    chk("clamp_sda", sda_oe, 1);
    run(1);

    // Reset mid-command aborts with no done
    issue(BIT, 1'b1, 6, 4);
    run(3);
    d0    = done_cnt;
    reset = 1'b1;
    #1;
    chk("mr_scl", scl_oe, 0);
    chk("mr_sda", sda_oe, 0);
    chk("mr_busy", bus_busy, 0);
    chk("mr_ready", tif.cmd_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    run(20);
    chk("mr_no_done", done_cnt - d0, 0);
    chk("mr_scl_idle", scl_oe, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
